// File: rtl/layer_scheduler_pkg.sv
// Shared types for the MLP layer scheduler: FSM states, the decoded control word,
// the default MAC latency and a minimum-one-bit clog2 width helper.
package layer_scheduler_pkg;

    localparam int MAC_LAT_DEFAULT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_BIAS  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic mac_clr;
        logic mac_en;
        logic use_bias;
        logic res_valid;
    } ctl_t;

    // Counter/index width; a one-entry range still needs one bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic ctl_t ctl_decode(input state_e s);
        ctl_t c;
        c = '0;
        case (s)
            ST_CLEAR: begin c.busy = 1'b1; c.mac_clr = 1'b1; end
            ST_ACCUM: begin c.busy = 1'b1; c.mac_en = 1'b1; end
            ST_BIAS:  begin c.busy = 1'b1; c.mac_en = 1'b1; c.use_bias = 1'b1; end
            ST_DRAIN: c.busy = 1'b1;
            ST_WRITE: begin c.busy = 1'b1; c.res_valid = 1'b1; end
            ST_DONE:  begin c.busy = 1'b1; c.done = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/layer_scheduler_index_counter.sv
// Wrapping index counter: async active-low reset, enable, synchronous clear,
// counts 0..MAX-1 and returns to 0 on the advance past MAX-1.
module index_counter #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == W'(MAX - 1)) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one shared MAC across every neuron of an MLP layer: clear, stream inputs,
// add bias, drain the MAC pipeline, then hand each result to the output buffer.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int N_INPUT        = 2,
    parameter int CLOG2_N_INPUT  = clog2w(N_INPUT),
    parameter int N_NEURON       = 4,
    parameter int CLOG2_N_NEURON = clog2w(N_NEURON),
    parameter int MAC_LAT        = MAC_LAT_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clk_en,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [CLOG2_N_NEURON-1:0] o_neuron_idx,
    output logic [CLOG2_N_INPUT-1:0]  o_in_addr,
    output logic                      o_mac_clr,
    output logic                      o_mac_en,
    output logic                      o_use_bias,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [CLOG2_N_NEURON-1:0] o_res_idx,
    output state_e                    o_state
);

    localparam int                DRAIN_W    = clog2w(MAC_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    state_e             r_state;
    state_e             w_next;
    ctl_t               r_ctl;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               w_last_in;
    logic               w_last_neuron;
    logic               w_handshake;

    assign w_last_in     = (o_in_addr == CLOG2_N_INPUT'(N_INPUT - 1));
    assign w_last_neuron = (o_neuron_idx == CLOG2_N_NEURON'(N_NEURON - 1));
    assign w_handshake   = (r_state == ST_WRITE) && i_res_ready;

    always_comb begin
        w_next = r_state;
        if (i_clk_en) begin
            case (r_state)
                ST_IDLE:  if (i_start) w_next = ST_CLEAR;
                ST_CLEAR: w_next = ST_ACCUM;
                ST_ACCUM: if (w_last_in) w_next = ST_BIAS;
                ST_BIAS:  w_next = (MAC_LAT == 0) ? ST_WRITE : ST_DRAIN;
                ST_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_next = ST_WRITE;
                ST_WRITE: if (i_res_ready) w_next = w_last_neuron ? ST_DONE : ST_CLEAR;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Control outputs are registered from the next state, so they always match r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_decode(w_next);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drain_cnt <= '0;
        end else if (i_clk_en) begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    // in_addr wraps to 0 on the last ACCUM beat, which is the address BIAS presents.
    index_counter #(.MAX(N_INPUT), .W(CLOG2_N_INPUT)) u_in_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_clk_en && (r_state == ST_ACCUM)),
        .i_clr   (i_clk_en && (r_state == ST_CLEAR)),
        .o_cnt   (o_in_addr)
    );

    index_counter #(.MAX(N_NEURON), .W(CLOG2_N_NEURON)) u_neuron_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_clk_en && w_handshake),
        .i_clr   (i_clk_en && (r_state == ST_IDLE) && i_start),
        .o_cnt   (o_neuron_idx)
    );

    assign o_busy      = r_ctl.busy;
    assign o_done      = r_ctl.done;
    assign o_mac_clr   = r_ctl.mac_clr;
    assign o_mac_en    = r_ctl.mac_en;
    assign o_use_bias  = r_ctl.use_bias;
    assign o_res_valid = r_ctl.res_valid;
    assign o_res_idx   = o_neuron_idx;
    assign o_state     = r_state;

endmodule
